// File: rtl/adt7320_responder.sv
// ADT7320 SPI responder: emulates the sensor's serial side with an 8-register map,
// live temperature on address 2, write strobes and the 32-ones interface reset.
module adt7320_responder (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] temp_in,
  input  logic        cs,
  input  logic        sclk,
  input  logic        din,
  output logic        dout,
  output logic        rd_stb,
  output logic        wr_stb,
  output logic [2:0]  wr_addr,
  output logic [15:0] wr_data,
  output logic [7:0]  config_out
);

  typedef enum logic [2:0] {IDLE, CMD, READ, WRITE, DONE} state_t;

  state_t      state;
  logic        cs_meta, cs_s;
  logic        sclk_meta, sclk_s, sclk_d;
  logic        din_meta, din_s;
  logic        sclk_rise, sclk_fall;
  logic [3:0]  bit_cnt;
  logic [5:0]  cmd_sr;
  logic [14:0] data_sr;
  logic [15:0] data_next;
  logic [15:0] shift_sr;
  logic [15:0] rd_value;
  logic [2:0]  addr_q;
  logic [4:0]  ones_cnt;
  logic        ones_hit;
  logic [7:0]  config_reg;
  logic [15:0] t_crit;
  logic [7:0]  t_hyst;
  logic [15:0] t_high;
  logic [15:0] t_low;

  function automatic logic is_wide(input logic [2:0] a);
    return (a == 3'd2) || (a == 3'd4) || (a == 3'd6) || (a == 3'd7);
  endfunction

  function automatic logic is_writable(input logic [2:0] a);
    return (a == 3'd1) || (a >= 3'd4);
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      cs_meta   <= 1'b1;
      cs_s      <= 1'b1;
      sclk_meta <= 1'b1;
      sclk_s    <= 1'b1;
      sclk_d    <= 1'b1;
      din_meta  <= 1'b0;
      din_s     <= 1'b0;
    end else begin
      cs_meta   <= cs;
      cs_s      <= cs_meta;
      sclk_meta <= sclk;
      sclk_s    <= sclk_meta;
      sclk_d    <= sclk_s;
      din_meta  <= din;
      din_s     <= din_meta;
    end
  end

  assign sclk_rise = sclk_s & ~sclk_d;
  assign sclk_fall = ~sclk_s & sclk_d;
  assign data_next = {data_sr, din_s};
  assign ones_hit  = sclk_rise & ~cs_s & din_s & (ones_cnt == 5'd31);
  assign config_out = config_reg;

  // Read data is left-justified; after the 7th rise cmd_sr[4:2] holds the address.
  always_comb begin
    rd_value = 16'hFFFF;
    case (cmd_sr[4:2])
      3'd0: rd_value = 16'h00FF;
      3'd1: rd_value = {config_reg, 8'hFF};
      3'd2: rd_value = temp_in;
      3'd3: rd_value = 16'hC3FF;
      3'd4: rd_value = t_crit;
      3'd5: rd_value = {t_hyst, 8'hFF};
      3'd6: rd_value = t_high;
      3'd7: rd_value = t_low;
      default: rd_value = 16'hFFFF;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      dout       <= 1'b1;
      rd_stb     <= 1'b0;
      wr_stb     <= 1'b0;
      wr_addr    <= 3'd0;
      wr_data    <= 16'h0000;
      bit_cnt    <= 4'd0;
      cmd_sr     <= 6'd0;
      data_sr    <= 15'd0;
      shift_sr   <= 16'hFFFF;
      addr_q     <= 3'd0;
      ones_cnt   <= 5'd0;
      config_reg <= 8'h00;
      t_crit     <= 16'h4980;
      t_hyst     <= 8'h05;
      t_high     <= 16'h2000;
      t_low      <= 16'h0500;
    end else begin
      rd_stb <= 1'b0;
      wr_stb <= 1'b0;

      if (cs_s)
        ones_cnt <= 5'd0;
      else if (sclk_rise)
        ones_cnt <= din_s ? ones_cnt + 5'd1 : 5'd0;

      if (cs_s) begin
        state   <= IDLE;
        dout    <= 1'b1;
        bit_cnt <= 4'd0;
      end else begin
        case (state)
          IDLE: begin
            dout    <= 1'b1;
            bit_cnt <= 4'd0;
            state   <= CMD;
          end
          CMD: if (sclk_rise) begin
            cmd_sr <= {cmd_sr[4:0], din_s};
            if (bit_cnt == 4'd7) begin
              bit_cnt <= 4'd0;
              addr_q  <= cmd_sr[4:2];
              if (cmd_sr[5]) begin
                shift_sr <= rd_value;
                rd_stb   <= 1'b1;
                state    <= READ;
              end else begin
                state <= WRITE;
              end
            end else begin
              bit_cnt <= bit_cnt + 4'd1;
            end
          end
          READ: if (sclk_fall) begin
            dout     <= shift_sr[15];
            shift_sr <= {shift_sr[14:0], 1'b1};
            if (bit_cnt == 4'd15) begin
              bit_cnt <= 4'd0;
              state   <= DONE;
            end else begin
              bit_cnt <= bit_cnt + 4'd1;
            end
          end
          WRITE: if (sclk_rise) begin
            data_sr <= data_next[14:0];
            if (bit_cnt == (is_wide(addr_q) ? 4'd15 : 4'd7)) begin
              bit_cnt <= 4'd0;
              state   <= DONE;
              if (is_writable(addr_q)) begin
                wr_stb  <= 1'b1;
                wr_addr <= addr_q;
                wr_data <= is_wide(addr_q) ? data_next : {8'h00, data_next[7:0]};
                case (addr_q)
                  3'd1:    config_reg <= data_next[7:0];
                  3'd4:    t_crit     <= data_next;
                  3'd5:    t_hyst     <= data_next[7:0];
                  3'd6:    t_high     <= data_next;
                  3'd7:    t_low      <= data_next;
                  default: ;
                endcase
              end
            end else begin
              bit_cnt <= bit_cnt + 4'd1;
            end
          end
          // The last data bit stays on dout until the master's next fall.
          DONE: if (sclk_fall) dout <= 1'b1;
          default: state <= IDLE;
        endcase
      end

      // Placed last so an interface reset overrides a write landing in the same clk.
      if (ones_hit) begin
        config_reg <= 8'h00;
        t_crit     <= 16'h4980;
        t_hyst     <= 8'h05;
        t_high     <= 16'h2000;
        t_low      <= 16'h0500;
      end
    end
  end

endmodule

// File: tb/tb_adt7320_responder.sv
// Self-checking bench for adt7320_responder: SPI master BFM, directed scenarios and
// randomized register traffic checked against an array-based register model.
`timescale 1ns/1ps
module tb_adt7320_responder;

  logic        clk = 1'b0;
  logic        reset, cs, sclk, din;
  logic [15:0] temp_in;
  logic        dout, rd_stb, wr_stb;
  logic [2:0]  wr_addr;
  logic [15:0] wr_data;
  logic [7:0]  config_out;

  int n_checks = 0;
  int n_fail   = 0;
  int rd_cnt   = 0;
  int wr_cnt   = 0;
  int half_ns  = 200;

  logic [15:0] mreg [8];

  adt7320_responder dut (
    .clk(clk), .reset(reset), .temp_in(temp_in), .cs(cs), .sclk(sclk), .din(din),
    .dout(dout), .rd_stb(rd_stb), .wr_stb(wr_stb), .wr_addr(wr_addr),
    .wr_data(wr_data), .config_out(config_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rd_stb) rd_cnt <= rd_cnt + 1;
    if (wr_stb) wr_cnt <= wr_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit m_wide(input int a);
    return (a == 2) || (a == 4) || (a == 6) || (a == 7);
  endfunction

  function automatic bit m_writable(input int a);
    return (a == 1) || (a >= 4);
  endfunction

  task automatic model_reset();
    mreg[0] = 16'h0000; mreg[1] = 16'h0000; mreg[2] = 16'h0000; mreg[3] = 16'h00C3;
    mreg[4] = 16'h4980; mreg[5] = 16'h0005; mreg[6] = 16'h2000; mreg[7] = 16'h0500;
  endtask

  function automatic logic [15:0] exp_read(input int a);
    if (a == 2) return temp_in;
    if (m_wide(a)) return mreg[a];
    return {mreg[a][7:0], 8'hFF};
  endfunction

  // Master: drive din on the fall, sample dout just before the rise.
  task automatic xfer(input int nbits, input logic [31:0] mosi, input bit hold,
                      output logic [31:0] miso);
    logic [31:0] m;
    m = mosi;
    miso = 32'h0;
    cs = 1'b0;
    #(half_ns);
    for (int i = 0; i < nbits; i++) begin
      sclk = 1'b0;
      din  = m[nbits-1-i];
      #(half_ns);
      miso = {miso[30:0], dout};
      sclk = 1'b1;
      #(half_ns);
    end
    if (!hold) begin
      cs  = 1'b1;
      din = 1'b0;
      #(half_ns);
    end
  endtask

  task automatic do_read(input int a, input string tag);
    logic [7:0]  cmd;
    logic [31:0] miso;
    int          r0;
    cmd = 8'($urandom);
    cmd[6] = 1'b1;
    cmd[5:3] = 3'(a);
    r0 = rd_cnt;
    xfer(24, {8'h00, cmd, 16'h0000}, 1'b0, miso);
    check(tag, miso[15:0], exp_read(a));
    check({tag, "_rdstb"}, rd_cnt - r0, 1);
  endtask

  task automatic do_write(input int a, input logic [15:0] data, input string tag);
    logic [7:0]  cmd;
    logic [31:0] miso;
    logic [15:0] v;
    int          n, w0;
    cmd = 8'($urandom);
    cmd[6] = 1'b0;
    cmd[5:3] = 3'(a);
    n = m_wide(a) ? 16 : 8;
    v = m_wide(a) ? data : {8'h00, data[7:0]};
    w0 = wr_cnt;
    xfer(8 + n, ({24'h0, cmd} << n) | {16'h0, v}, 1'b0, miso);
    if (m_writable(a)) begin
      mreg[a] = v;
      check({tag, "_wrstb"}, wr_cnt - w0, 1);
      check({tag, "_wraddr"}, wr_addr, a);
      check({tag, "_wrdata"}, wr_data, v);
    end else begin
      check({tag, "_nostb"}, wr_cnt - w0, 0);
    end
    check({tag, "_cfg"}, config_out, mreg[1][7:0]);
  endtask

  task automatic applyStimulus();
    logic [31:0] miso;
    int w0;

    reset = 1'b1; cs = 1'b1; sclk = 1'b1; din = 1'b0; temp_in = 16'h0C80;
    model_reset();
    repeat (4) @(negedge clk);
    check("rst_dout", dout, 1);
    check("rst_rdstb", rd_stb, 0);
    check("rst_wrstb", wr_stb, 0);
    check("rst_wraddr", wr_addr, 0);
    check("rst_wrdata", wr_data, 0);
    check("rst_cfg", config_out, 0);
    reset = 1'b0;
    repeat (4) @(negedge clk);

    half_ns = 1000;
    do_read(2, "rd_temp");
    half_ns = 200;
    do_read(3, "rd_id");
    do_read(4, "rd_tcrit");

    do_write(1, 16'h0080, "wr_cfg");
    do_read(1, "rd_cfg");

    w0 = wr_cnt;
    xfer(20, {12'h0, 8'h30, 12'hABC}, 1'b0, miso);
    check("abort_nostb", wr_cnt - w0, 0);
    do_read(6, "abort_thigh");
    do_read(4, "abort_tcrit");
    do_write(2, 16'h1234, "wr_ro");
    do_read(2, "rd_temp2");

    // Reset in the middle of reading config (bit 5 of 0x80FF is 0).
    xfer(14, {18'h0, 8'h48, 6'h00}, 1'b1, miso);
    @(negedge clk);
    check("midrd_dout", dout, 0);
    reset = 1'b1;
    @(negedge clk);
    check("midrst_dout", dout, 1);
    check("midrst_cfg", config_out, 0);
    reset = 1'b0;
    cs = 1'b1;
    model_reset();
    repeat (8) @(negedge clk);
    do_read(1, "post_rst_cfg");

    temp_in = 16'h0000;
    xfer(14, {18'h0, 8'h50, 6'h00}, 1'b1, miso);
    @(negedge clk);
    check("csab_dout0", dout, 0);
    cs = 1'b1;
    repeat (6) @(negedge clk);
    check("csab_dout1", dout, 1);
    repeat (4) @(negedge clk);

    do_write(6, 16'h1234, "wr_thigh");
    do_read(6, "rd_thigh");
    do_write(1, 16'h00A5, "wr_cfg2");
    w0 = wr_cnt;
    xfer(32, 32'hFFFF_FFFF, 1'b0, miso);
    model_reset();
    check("ifrst_nostb", wr_cnt - w0, 0);
    check("ifrst_cfg", config_out, 0);
    do_read(6, "ifrst_thigh");

    for (int i = 0; i < 24; i++) begin
      int a;
      a = int'($urandom_range(0, 7));
      temp_in = 16'($urandom);
      if ($urandom_range(0, 1) == 1)
        do_read(a, $sformatf("rnd_rd%0d_a%0d", i, a));
      else
        do_write(a, 16'($urandom), $sformatf("rnd_wr%0d_a%0d", i, a));
    end
  endtask

  task automatic checkOutput();
    $display("[TB] End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
  endtask

  initial begin
    applyStimulus();
    checkOutput();
    $finish;
  end

endmodule

// File: doc/adt7320_responder.md
# adt7320_responder

Synthesizable SPI responder that emulates an ADT7320 temperature sensor on the serial side of the 4-wire interface (CS*, SCLK, DIN, DOUT). It is used as an on-board or in-bench stand-in for the physical chip when exercising the ADT7320 readout master. It decodes command bytes and serves reads from an internal 8-register map, with live temperature taken from a port. It accepts writes to the writable registers and reports each committed write on a strobe.

## Interface
- No parameters.
- clk  input  1  100 MHz system-wide master clock
- reset  input  1  synchronous, active-high logic reset
- temp_in  input  16  temperature value served at address 2
- cs  input  1  chip-select*, active low, asynchronous to clk
- sclk  input  1  serial clock from master, idle high, asynchronous to clk
- din  input  1  serial data from master, asynchronous to clk
- dout  output  1  serial data to master, reg, idles 1
- rd_stb  output  1  one-clk pulse when a read command byte is decoded
- wr_stb  output  1  one-clk pulse when a write commits
- wr_addr  output  3  address of the last committed write
- wr_data  output  16  data of the last committed write; 8-bit registers are zero-extended
- config_out  output  8  current config register (addr 1)

## Operation
- **Synchronizers.** cs, sclk and din each pass through a 2-flop synchronizer. SCLK rise and fall are detected on the synchronized sclk (1-clk pulses).
- **Register map.** Width and reset value per address:
  - 0 status, 8 bits, reads constant 0x00, read-only.
  - 1 config, 8 bits, 0x00.
  - 2 temp, 16 bits, temp_in, read-only.
  - 3 ID, 8 bits, 0xC3, read-only.
  - 4 T_CRIT, 16 bits, 0x4980.
  - 5 T_HYST, 8 bits, 0x05.
  - 6 T_HIGH, 16 bits, 0x2000.
  - 7 T_LOW, 16 bits, 0x0500.
- **Command byte.** MSB first, sampled on SCLK rise. Bit6 = R/W* (1 = read), bits5:3 = addr. Bit7 and bits2:0 are ignored.
- **FSM states and transitions:**
  - IDLE: dout=1, bit counter cleared. Synchronized cs low → CMD.
  - CMD: shift din in on each rise. After the 8th rise, latch addr and R/W.
    - Read: load shift register with register value, left-justified in 16 bits. temp_in is captured at this clk for a coherent value. Pulse rd_stb. → READ.
    - Write: → WRITE.
  - READ: on each fall, dout ← shift MSB and shift left, filling with 1. 8-bit registers therefore shift out their 8 bits followed by 1s. After 16 falls → DONE.
  - WRITE: shift din in on each rise, 8 or 16 rises by register width.
    - On the final rise, a writable address updates the register and pulses wr_stb with wr_addr/wr_data.
    - A read-only address is discarded with no strobe.
    - Either way → DONE.
  - DONE: dout=1; SCLK edges are ignored.
- **cs deassertion.** Synchronized cs high in any state → IDLE the next clk with dout=1. An incomplete write is discarded.
- **Interface reset.** 32 consecutive 1s sampled on DIN rises while cs is low restore all register reset values, with no wr_stb. The ones count resets on any 0 or on cs high, and spans state boundaries.
- **reset.** FSM → IDLE. All registers are restored.

## Timing
- Reset values: dout=1, rd_stb=0, wr_stb=0, wr_addr=0, wr_data=0, config_out=0x00.
- Input to action latency is 3 clk (2 sync + 1 edge detect).
- dout is valid ≤4 clk after the SCLK fall that drives it. It is held until the next fall or cs deassertion.
- Data bit k (k=0 MSB) is driven on SCLK fall number 9+k. The master samples on the following rise.
- rd_stb is asserted 4 clk after the 8th SCLK rise. wr_stb is asserted 4 clk after the final data rise.
- Required SCLK high and low times are ≥8 clk each. The cs-low to first-fall setup is ≥8 clk.
- A write and a reset in the same clk: reset wins.

## Test plan
- Read temp: temp_in=0x0C80, BFM sends 0x50 with 1 µs half-periods and reads 16 bits → 0x0C80, one rd_stb.
- Read ID: command 0x58 → 0xC3FF. Read T_CRIT after reset: command 0x60 → 0x4980.
- Write config: command 0x08, data 0x80 → wr_stb once with wr_addr=1, wr_data=0x0080, config_out=0x80. A readback of 0x48 → 0x80FF.
- Aborted write: command 0x30, raise cs after 12 data bits → no wr_stb, T_CRIT stays 0x4980. Write 0x10 (addr 2, read-only) → no wr_stb.
- Mid-transfer disruption: assert reset during READ bit 5 → dout=1 the next clk, next read of addr 1 returns 0x00FF. Raise cs during READ → IDLE, dout=1.
- Interface reset: write T_HIGH=0x1234, then 32 DIN ones with cs low → T_HIGH readback 0x2000, config_out=0x00.
